flag_branch_unit: RTL

Consumer side of the ALU flag interface. Holds the architectural FLAG register {Z,V,N}, updates it from the EX-stage ALU using per-opcode write masks, and resolves conditional branches (B and BR) against it. A branch that would race a same-cycle flag write is stalled one cycle. The unit sits between EX (flag producer) and decode/fetch (branch consumer).

---
 rtl/flag_branch_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/flag_branch_unit.sv
// Architectural {Z,V,N} flag register with per-opcode write masks, plus a
// conditional branch resolver that stalls one cycle when a branch races a flag write.
module flag_branch_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [2:0]  ex_opcode,
   input  logic [2:0]  ex_flags_in,
   input  logic        br_valid,
   input  logic [2:0]  br_ccc,
   input  logic        br_reg,
   input  logic [8:0]  br_imm,
   input  logic [15:0] br_rs_data,
   input  logic [15:0] pc_plus2,
   output logic [2:0]  flags,
   output logic        br_stall,
   output logic        br_done,
   output logic        br_taken,
   output logic [15:0] br_target
);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t      state, state_next;
   logic        hazard;
   logic [2:0]  wr_mask_c;
   logic        capture, resolve, sel_held;

   logic [2:0]  hold_ccc;
   logic        hold_reg;
   logic [8:0]  hold_imm;
   logic [15:0] hold_rs_data;
   logic [15:0] hold_pc_plus2;

   logic [2:0]  r_ccc;
   logic        r_reg;
   logic [8:0]  r_imm;
   logic [15:0] r_rs_data;
   logic [15:0] r_pc_plus2;
   logic        taken_c;
   logic [15:0] target_c;

   // Mask bits are ordered {Z,V,N} to line up with the flag register.
   function automatic logic [2:0] flag_wr_mask(input logic [2:0] op);
      case (op)
         3'b000, 3'b001:                 flag_wr_mask = 3'b111;
         3'b010, 3'b100, 3'b101, 3'b110: flag_wr_mask = 3'b100;
         default:                        flag_wr_mask = 3'b000;
      endcase
   endfunction

   function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] f);
      logic z, v, n;
      z = f[2];
      v = f[1];
      n = f[0];
      case (ccc)
         3'b000:  cond_met = !z;
         3'b001:  cond_met = z;
         3'b010:  cond_met = !z && !n;
         3'b011:  cond_met = n;
         3'b100:  cond_met = z || (!z && !n);
         3'b101:  cond_met = n || z;
         3'b110:  cond_met = v;
         default: cond_met = 1'b1;
      endcase
   endfunction

   // Word offset: sign-extend the 9-bit immediate, then scale to bytes; sum wraps mod 2^16.
   function automatic logic [15:0] branch_dest(input logic [15:0] pc, input logic [8:0] imm);
      logic signed [15:0] offset;
      offset = signed'({{6{imm[8]}}, imm, 1'b0});
      branch_dest = pc + unsigned'(offset);
   endfunction

   always_comb begin
      wr_mask_c = flag_wr_mask(ex_opcode);
      hazard    = ex_valid && (wr_mask_c != 3'b000);
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      resolve    = 1'b0;
      sel_held   = 1'b0;
      br_stall   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (br_valid) begin
               if (hazard) begin
                  capture    = 1'b1;
                  br_stall   = 1'b1;
                  state_next = ST_WAIT;
               end else begin
                  resolve = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            br_stall = 1'b1;
            sel_held = 1'b1;
            if (!hazard) begin
               resolve    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      r_ccc      = sel_held ? hold_ccc      : br_ccc;
      r_reg      = sel_held ? hold_reg      : br_reg;
      r_imm      = sel_held ? hold_imm      : br_imm;
      r_rs_data  = sel_held ? hold_rs_data  : br_rs_data;
      r_pc_plus2 = sel_held ? hold_pc_plus2 : pc_plus2;
      taken_c    = cond_met(r_ccc, flags);
      if (!taken_c)
         target_c = r_pc_plus2;
      else if (r_reg)
         target_c = r_rs_data;
      else
         target_c = branch_dest(r_pc_plus2, r_imm);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         flags         <= 3'b000;
         br_done       <= 1'b0;
         br_taken      <= 1'b0;
         br_target     <= 16'h0000;
         hold_ccc      <= 3'b000;
         hold_reg      <= 1'b0;
         hold_imm      <= 9'h000;
         hold_rs_data  <= 16'h0000;
         hold_pc_plus2 <= 16'h0000;
      end else begin
         state   <= state_next;
         br_done <= resolve;
         if (ex_valid)
            flags <= (flags & ~wr_mask_c) | (ex_flags_in & wr_mask_c);
         if (resolve) begin
            br_taken  <= taken_c;
            br_target <= target_c;
         end
         if (capture) begin
            hold_ccc      <= br_ccc;
            hold_reg      <= br_reg;
            hold_imm      <= br_imm;
            hold_rs_data  <= br_rs_data;
            hold_pc_plus2 <= pc_plus2;
         end
      end
   end

endmodule
